imm_extender: RTL and testbench

Parametrised, pipelined immediate-generation stage that replaces the fixed 16→32 sign extender in the decode path. It accepts an `IN_W`-bit immediate plus a 2-bit extension mode over a valid/ready handshake. It produces a registered `OUT_W`-bit operand through a two-entry skid buffer, so both `io_in_ready` and the output are driven from flops. It sits between instruction decode and the ALU operand mux.

---
 rtl/imm_extender.sv | 112 +++++++++++
 tb/tb_imm_extender.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extender.sv
// imm_extender: pipelined immediate extender (SEXT/ZEXT/UPPER/BRANCH) with a two-entry skid buffer.
// Optional feature: define IMMEXT_STATS_EN to add io_count, a saturating count of completed outputs.
module imm_extender #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [IN_W-1:0]  io_in_imm,
    input  logic [1:0]       io_in_mode,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [OUT_W-1:0] io_out_imm
`ifdef IMMEXT_STATS_EN
    ,
    output logic [15:0]      io_count
`endif
);

    generate
        if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_width
            $error("imm_extender: need IN_W >= 2 and OUT_W >= IN_W + 2");
        end
    endgenerate

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d, skid_q, skid_d;
    logic             out_valid_q, in_ready_q;
    logic [OUT_W-1:0] sext, zext, upper, res;
    logic             in_fire, out_fire;

    assign in_fire      = io_in_valid & in_ready_q;
    assign out_fire     = out_valid_q & io_out_ready;
    assign io_in_ready  = in_ready_q;
    assign io_out_valid = out_valid_q;
    assign io_out_imm   = main_q;

    // Extend the incoming immediate according to the requested mode.
    always_comb begin
        sext  = {{(OUT_W-IN_W){io_in_imm[IN_W-1]}}, io_in_imm};
        zext  = {{(OUT_W-IN_W){1'b0}}, io_in_imm};
        upper = {io_in_imm, {(OUT_W-IN_W){1'b0}}};
        res   = (io_in_mode == 2'd0) ? sext :
                (io_in_mode == 2'd1) ? zext :
                (io_in_mode == 2'd2) ? upper : sext << 2;
    end

    // Skid-buffer next state: MAIN always holds the oldest entry, SKID the younger one.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = res;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = res;
                end else if (in_fire) begin
                    skid_d  = res;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Register state and outputs; ready and valid come from next state so both are pure flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= state_d != EMPTY;
            in_ready_q  <= state_d != FULL;
        end
    end

`ifdef IMMEXT_STATS_EN
    logic [15:0] count_q;
    assign io_count = count_q;

    // Count completed outputs, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else if (out_fire && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_imm_extender.sv
// tb_imm_extender: table vectors, backpressure/reset sequences and a scoreboarded random stream.
module tb_imm_extender;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic [15:0] io_in_imm = '0;
    logic [1:0]  io_in_mode = '0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [31:0] io_out_imm;
`ifdef IMMEXT_STATS_EN
    logic [15:0] io_count;
`endif

    imm_extender dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_in_imm   (io_in_imm),
        .io_in_mode  (io_in_mode),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_imm  (io_out_imm)
`ifdef IMMEXT_STATS_EN
        ,
        .io_count    (io_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: value-level arithmetic on the immediate, reduced modulo 2^32.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        longint v;
        longint r;
        v = imm[15] ? longint'(imm) - 65536 : longint'(imm);
        case (mode)
            2'd0:    r = v;
            2'd1:    r = longint'(imm);
            2'd2:    r = longint'(imm) * 65536;
            default: r = v * 4;
        endcase
        return r[31:0];
    endfunction

    logic [31:0] q[$];
    int          sent, recv;
    logic        r_before, acc;
    logic [31:0] head;

    initial begin
        vecs[0] = '{16'h8000, 2'd0, 32'hFFFF8000};
        vecs[1] = '{16'h8000, 2'd1, 32'h00008000};
        vecs[2] = '{16'h7FFF, 2'd0, 32'h00007FFF};
        vecs[3] = '{16'h1234, 2'd2, 32'h12340000};
        vecs[4] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        vecs[5] = '{16'h4000, 2'd3, 32'h00010000};

        step();
        step();
        chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);
        chk("rst_out_imm", io_out_imm, 32'd0);
`ifdef IMMEXT_STATS_EN
        chk("rst_count", {16'd0, io_count}, 32'd0);
`endif
        reset = 1'b0;
        io_out_ready = 1'b1;
        step();
        chk("empty_no_bypass", {31'd0, io_out_valid}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            io_in_valid = 1'b1;
            io_in_imm = vecs[i].imm;
            io_in_mode = vecs[i].mode;
            step();
            io_in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, io_out_valid}, 32'd1);
            chk($sformatf("vec%0d_imm", i), io_out_imm, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_drain", i), {31'd0, io_out_valid}, 32'd0);
        end

        io_out_ready = 1'b0;
        io_in_mode = 2'd0;
        io_in_valid = 1'b1;
        io_in_imm = 16'h0001;
        step();
        chk("bp_a_imm", io_out_imm, 32'h1);
        chk("bp_a_ready", {31'd0, io_in_ready}, 32'd1);
        io_in_imm = 16'h0002;
        step();
        chk("bp_b_ready_low", {31'd0, io_in_ready}, 32'd0);
        chk("bp_hold_a", io_out_imm, 32'h1);
        io_in_imm = 16'h0003;
        step();
        chk("bp_c_held_off", {31'd0, io_in_ready}, 32'd0);
        chk("bp_hold_a2", io_out_imm, 32'h1);
        io_out_ready = 1'b1;
        step();
        chk("bp_out_b", io_out_imm, 32'h2);
        chk("bp_ready_back", {31'd0, io_in_ready}, 32'd1);
        step();
        io_in_valid = 1'b0;
        chk("bp_out_c", io_out_imm, 32'h3);
        chk("bp_out_c_valid", {31'd0, io_out_valid}, 32'd1);
        step();
        chk("bp_drained", {31'd0, io_out_valid}, 32'd0);

        sent = 0;
        recv = 0;
        io_in_imm = 16'($urandom);
        io_in_mode = 2'($urandom);
        for (int c = 0; c < 3000 && recv < 100; c++) begin
            io_in_valid = sent < 100;
            io_out_ready = 1'($urandom_range(0, 1));
            r_before = io_in_ready;
            io_out_ready = ~io_out_ready;
            #1;
            chk("ready_indep", {31'd0, io_in_ready}, {31'd0, r_before});
            io_out_ready = ~io_out_ready;
            #1;
            if (io_out_valid && io_out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_extra", io_out_imm, 32'hxxxxxxxx);
                end else begin
                    head = q.pop_front();
                    chk("stream_data", io_out_imm, head);
                end
                recv++;
            end
            acc = io_in_valid && io_in_ready;
            if (acc) begin
                q.push_back(model(io_in_imm, io_in_mode));
                sent++;
            end
            step();
            if (acc) begin
                io_in_imm = 16'($urandom);
                io_in_mode = 2'($urandom);
            end
        end
        io_in_valid = 1'b0;
        chk("stream_sent", sent, 32'd100);
        chk("stream_recv", recv, 32'd100);
        chk("stream_leftover", q.size(), 32'd0);

        io_out_ready = 1'b0;
        io_in_valid = 1'b1;
        io_in_mode = 2'd1;
        io_in_imm = 16'h00AA;
        step();
        io_in_imm = 16'h00BB;
        step();
        chk("rf_full", {31'd0, io_in_ready}, 32'd0);
        io_in_valid = 1'b0;
        reset = 1'b1;
        io_out_ready = 1'b1;
        step();
        chk("rf_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rf_in_ready", {31'd0, io_in_ready}, 32'd1);
        reset = 1'b0;
        io_in_valid = 1'b1;
        io_in_mode = 2'd3;
        io_in_imm = 16'h8000;
        step();
        io_in_valid = 1'b0;
        chk("rf_post_valid", {31'd0, io_out_valid}, 32'd1);
        chk("rf_post_imm", io_out_imm, model(16'h8000, 2'd3));
        step();
        chk("rf_post_drain", {31'd0, io_out_valid}, 32'd0);

`ifdef IMMEXT_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        io_out_ready = 1'b1;
        io_in_valid = 1'b1;
        io_in_mode = 2'd0;
        repeat (70005) step();
        chk("count_sat", {16'd0, io_count}, 32'h0000FFFF);
        repeat (5) step();
        chk("count_hold", {16'd0, io_count}, 32'h0000FFFF);
        io_in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("count_reset", {16'd0, io_count}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
